// File: rtl/fifo_ndepth.sv
// Parametrised N-entry show-ahead FIFO with level count and almost-full flag.
// Define FIFO_ND_ERRCHK_EN to add sticky ovf/udf error flags with err_clr.
module fifo_ndepth #(
  parameter int dw    = 8,
  parameter int depth = 4,
  parameter int aw    = 2,
  parameter int af_th = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [dw-1:0] dati,
  output logic          full,
  output logic          almost_full,
  output logic [dw-1:0] dato,
  output logic          empty,
  input  logic          re,
`ifdef FIFO_ND_ERRCHK_EN
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr,
`endif
  output logic [aw:0]   level
);

  localparam logic [aw:0]   DL   = (aw+1)'(depth);
  localparam logic [aw:0]   AF   = (aw+1)'(af_th);
  localparam logic [aw-1:0] LAST = aw'(depth - 1);

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wptr;
  logic [aw-1:0] rptr;
  logic          push;
  logic          pop;

  assign empty       = (level == '0);
  // A pop in the same cycle frees a slot, so full drops while re is high
  assign full        = (level == DL) & ~re;
  assign almost_full = (level >= AF);
  assign push        = we & ~full;
  assign pop         = re & ~empty;
  assign dato        = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dati;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (push & ~pop)      level <= level + 1'b1;
      else if (pop & ~push) level <= level - 1'b1;
    end
  end

`ifdef FIFO_ND_ERRCHK_EN
  // A new error event beats a same-cycle err_clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (we & full)   ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (re & empty)  udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
    end
  end
`endif

endmodule
